// File: rtl/vend_ctrl_if.sv
// vend_ctrl_if: coin-sense inputs and vend/return outputs of the vend controller
//   master: coin mechanism side (drives N, D, Q, cancel; observes the rest)
//   slave : vend_ctrl side (drives Dispense, ReturnNickle, ReturnDime, CoinReject, busy, credit, vend_count)
interface vend_ctrl_if #(
  parameter int CREDIT_W = 8,
  parameter int CNT_W    = 16
);
  logic                N;
  logic                D;
  logic                Q;
  logic                cancel;
  logic                Dispense;
  logic                ReturnNickle;
  logic                ReturnDime;
  logic                CoinReject;
  logic                busy;
  logic [CREDIT_W-1:0] credit;
  logic [CNT_W-1:0]    vend_count;
  modport master (
    output N, D, Q, cancel,
    input  Dispense, ReturnNickle, ReturnDime, CoinReject, busy, credit, vend_count
  );
  modport slave (
    input  N, D, Q, cancel,
    output Dispense, ReturnNickle, ReturnDime, CoinReject, busy, credit, vend_count
  );
endinterface

// File: rtl/vend_ctrl.sv
// vend_ctrl: accumulates coin credit to PRICE, pulses Dispense, then returns change one coin per cycle
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : vend_ctrl_if.slave (coin sense in; dispense/return/reject pulses, busy, credit, vend_count out)
module vend_ctrl #(
  parameter int PRICE    = 25,
  parameter int CREDIT_W = 8,
  parameter int CNT_W    = 16
) (
  input logic        clk,
  input logic        rst,
  vend_ctrl_if.slave bus
);
  if ((PRICE % 5) != 0 || PRICE < 5 || PRICE > 250 || (PRICE + 20) >= (1 << CREDIT_W)) begin : g_bad_param
    $error("vend_ctrl: PRICE must be a multiple of 5 in 5..250 and CREDIT_W must hold PRICE+20");
  end
  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;
  localparam logic [CREDIT_W-1:0] P   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] C5  = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] C10 = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] C25 = CREDIT_W'(25);
  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, coin_val;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                any_coin, take_coin;
  assign any_coin  = bus.N | bus.D | bus.Q;
  assign take_coin = state_q == IDLE && !bus.cancel;
  assign coin_val  = bus.Q ? C25 : bus.D ? C10 : bus.N ? C5 : '0;
  // when a coin is accepted only the lower-priority extras bounce; otherwise every sensed coin bounces
  assign bus.CoinReject   = take_coin ? ((bus.Q & (bus.D | bus.N)) | (bus.D & bus.N)) : any_coin;
  assign bus.Dispense     = state_q == VEND;
  assign bus.ReturnDime   = state_q == CHANGE && credit_q >= C10;
  assign bus.ReturnNickle = state_q == CHANGE && credit_q == C5;
  assign bus.busy         = state_q != IDLE;
  assign bus.credit       = credit_q;
  assign bus.vend_count   = cnt_q;
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.cancel) begin
          state_d = credit_q != '0 ? CHANGE : IDLE;
        end else if (any_coin) begin
          credit_d = credit_q + coin_val;
          state_d  = credit_d >= P ? VEND : IDLE;
        end
      end
      VEND: begin
        credit_d = credit_q - P;
        cnt_d    = &cnt_q ? cnt_q : cnt_q + 1'b1;
        state_d  = credit_d != '0 ? CHANGE : IDLE;
      end
      CHANGE: begin
        // credit is a multiple of 5, so below 10 it can only be the final nickel
        credit_d = credit_q >= C10 ? credit_q - C10 : '0;
        state_d  = credit_d == '0 ? IDLE : CHANGE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed scoreboard bench for vend_ctrl (PRICE 25, 3-bit sales counter)
module tb_vend_ctrl;
  localparam int CW = 8;
  localparam int NW = 3;
  localparam logic [3:0] DSP = 4'b1000;
  localparam logic [3:0] RD  = 4'b0100;
  localparam logic [3:0] RN  = 4'b0010;
  localparam logic [3:0] CR  = 4'b0001;
  typedef logic [15:0] rec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  rec_t sb[$];
  always #5 clk = ~clk;
  vend_ctrl_if #(.CREDIT_W(CW), .CNT_W(NW)) bus();
  vend_ctrl #(.PRICE(25), .CREDIT_W(CW), .CNT_W(NW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  function automatic rec_t mk(logic [3:0] ev, int cr, int cn, logic b);
    return {ev, 8'(cr), 3'(cn), b};
  endfunction
  always @(negedge clk) begin
    rec_t act;
    rec_t e;
    act = {bus.Dispense, bus.ReturnDime, bus.ReturnNickle, bus.CoinReject, bus.credit, bus.vend_count, bus.busy};
    if (mon_en && act[15:12] != 4'b0000) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event act{ev,credit,cnt,busy}=%h at %0t", act, $time);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL event act{ev,credit,cnt,busy}=%h exp=%h at %0t", act, e, $time);
        end
      end
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input logic n, input logic d, input logic q, input logic c);
    bus.N = n;
    bus.D = d;
    bus.Q = q;
    bus.cancel = c;
    @(posedge clk);
    #1;
    bus.N = 1'b0;
    bus.D = 1'b0;
    bus.Q = 1'b0;
    bus.cancel = 1'b0;
  endtask
  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic chk_rest(input string nm, input int cr, input int cn);
    chk({nm, "_credit"}, int'(bus.credit), cr);
    chk({nm, "_count"}, int'(bus.vend_count), cn);
    chk({nm, "_busy"}, int'(bus.busy), 0);
  endtask
  initial begin
    bus.N = 1'b0;
    bus.D = 1'b0;
    bus.Q = 1'b0;
    bus.cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_rest("reset", 0, 0);
    chk("reset_pulses", int'({bus.Dispense, bus.ReturnDime, bus.ReturnNickle, bus.CoinReject}), 0);
    rst = 1'b1;
    mon_en = 1'b1;
    sb.push_back(mk(DSP, 25, 0, 1'b1));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("q_vend_busy", int'(bus.busy), 1);
    idle(1);
    chk_rest("single_q", 0, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ndq_credit_n", int'(bus.credit), 5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("ndq_credit_d", int'(bus.credit), 15);
    sb.push_back(mk(DSP, 40, 1, 1'b1));
    sb.push_back(mk(RD, 15, 2, 1'b1));
    sb.push_back(mk(RN, 5, 2, 1'b1));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ndq_credit_q", int'(bus.credit), 40);
    idle(3);
    chk_rest("ndq", 0, 2);
    sb.push_back(mk(DSP, 45, 2, 1'b1));
    sb.push_back(mk(RD, 20, 3, 1'b1));
    sb.push_back(mk(RD, 10, 3, 1'b1));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk_rest("ddq", 0, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk(RD, 15, 3, 1'b1));
    sb.push_back(mk(RN, 5, 3, 1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk_rest("cancel", 0, 3);
    sb.push_back(mk(CR, 0, 3, 1'b0));
    sb.push_back(mk(DSP, 25, 3, 1'b1));
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk_rest("qn_same", 0, 4);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk(CR, 5, 4, 1'b0));
    sb.push_back(mk(DSP, 30, 4, 1'b1));
    sb.push_back(mk(RN | CR, 5, 5, 1'b1));
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_rest("d_in_change", 0, 5);
    sb.push_back(mk(DSP, 45, 5, 1'b1));
    sb.push_back(mk(RD, 20, 6, 1'b1));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk_rest("mid_change_reset", 0, 0);
    chk("mid_change_reset_pulses", int'({bus.Dispense, bus.ReturnDime, bus.ReturnNickle, bus.CoinReject}), 0);
    idle(3);
    for (int i = 0; i < 8; i++) begin
      sb.push_back(mk(DSP, 25, i, 1'b1));
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
    end
    chk_rest("saturate", 0, 7);
    idle(2);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
